// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline slice: ALU operation codes,
// destination-register select codes and default widths.
package mips_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned REGW_DEF  = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_NOR  = 4'b1100
    } alu_op_e;

    // 2'b11 is unnamed on purpose: it falls back to rt like DST_RT.
    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } reg_dst_e;

endpackage

// File: rtl/exe_pipe_slice_alu.sv
// Execute-stage ALU: combinational, wrap-around arithmetic, zero flag.
// Unlisted op codes produce 0.
module alu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    logic           lt_s;
    logic           lt_u;

    assign sh   = a[SHW-1:0];
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        result = '0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_NOR:  result = ~(a | b);
            ALU_SLL:  result = b << sh;
            ALU_SRL:  result = b >> sh;
            ALU_SRA:  result = $unsigned($signed(b) >>> sh);
            ALU_LUI:  result = b << 16;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exe_pipe_slice.sv
// Execute slice of the 5-stage MIPS pipeline: ID/EX register, operand and
// destination muxes, ALU, and EX/MEM register.
module exe_pipe_slice
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned REGW  = REGW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] inst_extended_id,
    input  logic [WIDTH-1:0] reg_data1_id,
    input  logic [WIDTH-1:0] reg_data2_id,
    input  logic [REGW-1:0]  rt_id,
    input  logic [REGW-1:0]  rd_id,
    input  logic [WIDTH-1:0] pc_id,
    input  logic [1:0]       RegDst_id,
    input  logic [3:0]       AluOp_id,
    input  logic             AluSrc_id,
    input  logic             AluSrc1_id,
    input  logic             MemRead_id,
    input  logic             MemWrite_id,
    input  logic             MemtoReg_id,
    input  logic             DataC_id,
    input  logic             RegWrite_id,
    output logic [REGW-1:0]  write_reg_exe,
    output logic             RegWrite_exe,
    output logic             MemRead_exe,
    output logic [WIDTH-1:0] alu_result_mem,
    output logic [WIDTH-1:0] write_data_mem,
    output logic [REGW-1:0]  write_reg_mem,
    output logic [WIDTH-1:0] pc_mem,
    output logic             zero_mem,
    output logic             MemRead_mem,
    output logic             MemWrite_mem,
    output logic             MemtoReg_mem,
    output logic             DataC_mem,
    output logic             RegWrite_mem
);

    logic [WIDTH-1:0] imm_ex, rd1_ex, rd2_ex, pc_ex;
    logic [REGW-1:0]  rt_ex, rd_ex;
    logic [1:0]       regdst_ex;
    logic [3:0]       aluop_ex;
    logic             alusrc_ex, alusrc1_ex;
    logic             memwrite_ex, memtoreg_ex, datac_ex;

    logic [WIDTH-1:0] op_a, op_b, alu_y;
    logic             alu_z;

    // A flush bubble is simply an all-zero ID/EX entry, same as reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            imm_ex       <= '0;
            rd1_ex       <= '0;
            rd2_ex       <= '0;
            pc_ex        <= '0;
            rt_ex        <= '0;
            rd_ex        <= '0;
            regdst_ex    <= '0;
            aluop_ex     <= '0;
            alusrc_ex    <= 1'b0;
            alusrc1_ex   <= 1'b0;
            MemRead_exe  <= 1'b0;
            memwrite_ex  <= 1'b0;
            memtoreg_ex  <= 1'b0;
            datac_ex     <= 1'b0;
            RegWrite_exe <= 1'b0;
        end else begin
            imm_ex       <= inst_extended_id;
            rd1_ex       <= reg_data1_id;
            rd2_ex       <= reg_data2_id;
            pc_ex        <= pc_id;
            rt_ex        <= rt_id;
            rd_ex        <= rd_id;
            regdst_ex    <= RegDst_id;
            aluop_ex     <= AluOp_id;
            alusrc_ex    <= AluSrc_id;
            alusrc1_ex   <= AluSrc1_id;
            MemRead_exe  <= MemRead_id;
            memwrite_ex  <= MemWrite_id;
            memtoreg_ex  <= MemtoReg_id;
            datac_ex     <= DataC_id;
            RegWrite_exe <= RegWrite_id;
        end
    end

    assign op_a = alusrc1_ex ? {{(WIDTH-5){1'b0}}, imm_ex[10:6]} : rd1_ex;
    assign op_b = alusrc_ex  ? imm_ex : rd2_ex;

    always_comb begin
        write_reg_exe = rt_ex;
        case (regdst_ex)
            DST_RD:  write_reg_exe = rd_ex;
            DST_RA:  write_reg_exe = '1;
            default: write_reg_exe = rt_ex;
        endcase
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (aluop_ex),
        .result (alu_y),
        .zero   (alu_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_mem <= '0;
            write_data_mem <= '0;
            write_reg_mem  <= '0;
            pc_mem         <= '0;
            zero_mem       <= 1'b0;
            MemRead_mem    <= 1'b0;
            MemWrite_mem   <= 1'b0;
            MemtoReg_mem   <= 1'b0;
            DataC_mem      <= 1'b0;
            RegWrite_mem   <= 1'b0;
        end else begin
            alu_result_mem <= alu_y;
            write_data_mem <= rd2_ex;
            write_reg_mem  <= write_reg_exe;
            pc_mem         <= pc_ex;
            zero_mem       <= alu_z;
            MemRead_mem    <= MemRead_exe;
            MemWrite_mem   <= memwrite_ex;
            MemtoReg_mem   <= memtoreg_ex;
            DataC_mem      <= datac_ex;
            RegWrite_mem   <= RegWrite_exe;
        end
    end

endmodule

// File: tb/tb_exe_pipe_slice.sv
// Directed self-checking bench for exe_pipe_slice with hand-computed results.
module tb_exe_pipe_slice;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] inst_extended_id, reg_data1_id, reg_data2_id, pc_id;
    logic [4:0]  rt_id, rd_id;
    logic [1:0]  RegDst_id;
    logic [3:0]  AluOp_id;
    logic        AluSrc_id, AluSrc1_id;
    logic        MemRead_id, MemWrite_id, MemtoReg_id, DataC_id, RegWrite_id;
    logic [4:0]  write_reg_exe, write_reg_mem;
    logic        RegWrite_exe, MemRead_exe;
    logic [31:0] alu_result_mem, write_data_mem, pc_mem;
    logic        zero_mem, MemRead_mem, MemWrite_mem, MemtoReg_mem, DataC_mem, RegWrite_mem;

    int total = 0;
    int bad   = 0;

    exe_pipe_slice #(.WIDTH(32), .REGW(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .inst_extended_id (inst_extended_id),
        .reg_data1_id     (reg_data1_id),
        .reg_data2_id     (reg_data2_id),
        .rt_id            (rt_id),
        .rd_id            (rd_id),
        .pc_id            (pc_id),
        .RegDst_id        (RegDst_id),
        .AluOp_id         (AluOp_id),
        .AluSrc_id        (AluSrc_id),
        .AluSrc1_id       (AluSrc1_id),
        .MemRead_id       (MemRead_id),
        .MemWrite_id      (MemWrite_id),
        .MemtoReg_id      (MemtoReg_id),
        .DataC_id         (DataC_id),
        .RegWrite_id      (RegWrite_id),
        .write_reg_exe    (write_reg_exe),
        .RegWrite_exe     (RegWrite_exe),
        .MemRead_exe      (MemRead_exe),
        .alu_result_mem   (alu_result_mem),
        .write_data_mem   (write_data_mem),
        .write_reg_mem    (write_reg_mem),
        .pc_mem           (pc_mem),
        .zero_mem         (zero_mem),
        .MemRead_mem      (MemRead_mem),
        .MemWrite_mem     (MemWrite_mem),
        .MemtoReg_mem     (MemtoReg_mem),
        .DataC_mem        (DataC_mem),
        .RegWrite_mem     (RegWrite_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        flush = 1'b0; inst_extended_id = '0; reg_data1_id = '0; reg_data2_id = '0;
        pc_id = '0; rt_id = '0; rd_id = '0; RegDst_id = '0; AluOp_id = '0;
        AluSrc_id = 1'b0; AluSrc1_id = 1'b0; MemRead_id = 1'b0; MemWrite_id = 1'b0;
        MemtoReg_id = 1'b0; DataC_id = 1'b0; RegWrite_id = 1'b0;
    endtask

    // Register-register op, result checked two edges after it is presented.
    task automatic rr_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        clr_in();
        AluOp_id = op; reg_data1_id = a; reg_data2_id = b;
        tick();
        clr_in();
        tick();
        chk(tag, alu_result_mem, exp);
        chk({tag, "_z"}, {31'b0, zero_mem}, {31'b0, exp == 32'h0});
    endtask

    logic [3:0]  t_op  [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0101,
                                4'b1000, 4'b0100, 4'b1010, 4'b1111, 4'b0110};
    logic [31:0] t_a   [10] = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd4,
                                32'd4, 32'd33, 32'd0, 32'hFFFF, 32'd3};
    logic [31:0] t_b   [10] = '{32'hFF00, 32'hFF00, 32'hFF00, 32'hFF00, 32'h8000_0000,
                                32'h8000_0000, 32'd1, 32'h1234, 32'hFFFF, 32'd5};
    logic [31:0] t_exp [10] = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'hFFFF_000F, 32'h0800_0000,
                                32'hF800_0000, 32'd2, 32'h1234_0000, 32'h0, 32'hFFFF_FFFE};

    initial begin
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_alu", alu_result_mem, 32'h0);
        chk("rst_wreg", {27'b0, write_reg_mem}, 32'h0);
        chk("rst_regwr_exe", {31'b0, RegWrite_exe}, 32'h0);
        rst = 1'b0;

        // ADD r-type
        AluOp_id = 4'b0010; reg_data1_id = 32'd5; reg_data2_id = 32'd7;
        RegDst_id = 2'b01; rd_id = 5'd3; rt_id = 5'd9; RegWrite_id = 1'b1;
        tick();
        clr_in();
        tick();
        chk("add_res", alu_result_mem, 32'd12);
        chk("add_wreg", {27'b0, write_reg_mem}, 32'd3);
        chk("add_regwr", {31'b0, RegWrite_mem}, 32'd1);
        chk("add_zero", {31'b0, zero_mem}, 32'd0);

        rr_op("sub_eq", 4'b0110, 32'h1234, 32'h1234, 32'h0);
        rr_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        rr_op("sltu", 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        for (int unsigned i = 0; i < 10; i++)
            rr_op($sformatf("tbl%0d", i), t_op[i], t_a[i], t_b[i], t_exp[i]);

        // SLL via shamt, then SRA by 31
        clr_in();
        AluSrc1_id = 1'b1; inst_extended_id = 32'h0000_0100; reg_data2_id = 32'h3; AluOp_id = 4'b0100;
        tick();
        clr_in();
        AluSrc1_id = 1'b1; inst_extended_id = 32'h0000_07C0; reg_data2_id = 32'h8000_0000; AluOp_id = 4'b1000;
        reg_data1_id = 32'h5;
        tick();
        chk("sll_shamt", alu_result_mem, 32'h30);
        clr_in();
        tick();
        chk("sra31", alu_result_mem, 32'hFFFF_FFFF);

        // store with negative immediate
        AluSrc_id = 1'b1; inst_extended_id = 32'hFFFF_FFFC; reg_data1_id = 32'h100;
        reg_data2_id = 32'hDEAD; AluOp_id = 4'b0010; MemWrite_id = 1'b1;
        tick();
        clr_in();
        tick();
        chk("st_addr", alu_result_mem, 32'hFC);
        chk("st_data", write_data_mem, 32'hDEAD);
        chk("st_memwr", {31'b0, MemWrite_mem}, 32'd1);
        chk("st_regwr", {31'b0, RegWrite_mem}, 32'd0);

        // JAL link
        RegDst_id = 2'b10; pc_id = 32'h40; rt_id = 5'd7; rd_id = 5'd8; RegWrite_id = 1'b1;
        tick();
        chk("jal_wreg_exe", {27'b0, write_reg_exe}, 32'd31);
        clr_in();
        tick();
        chk("jal_wreg_mem", {27'b0, write_reg_mem}, 32'd31);
        chk("jal_pc", pc_mem, 32'h40);

        // RegDst 11 selects rt
        RegDst_id = 2'b11; rt_id = 5'd6; rd_id = 5'd12;
        tick();
        chk("dst11_rt", {27'b0, write_reg_exe}, 32'd6);
        clr_in();

        // flush: bubble enters EX while EX/MEM still takes the older instruction
        AluOp_id = 4'b0010; reg_data1_id = 32'd5; reg_data2_id = 32'd6; MemWrite_id = 1'b1;
        tick();
        clr_in();
        flush = 1'b1; MemWrite_id = 1'b1; MemRead_id = 1'b1; RegWrite_id = 1'b1;
        reg_data1_id = 32'd1; AluOp_id = 4'b0010;
        tick();
        chk("fl_regwr_exe", {31'b0, RegWrite_exe}, 32'd0);
        chk("fl_memrd_exe", {31'b0, MemRead_exe}, 32'd0);
        chk("fl_keep_memwr", {31'b0, MemWrite_mem}, 32'd1);
        chk("fl_keep_res", alu_result_mem, 32'd11);
        clr_in();
        tick();
        chk("fl_memwr_mem", {31'b0, MemWrite_mem}, 32'd0);
        chk("fl_res_mem", alu_result_mem, 32'd0);

        // reset mid-stream with both registers occupied
        AluOp_id = 4'b0001; reg_data1_id = 32'hA; reg_data2_id = 32'h50; RegWrite_id = 1'b1;
        MemtoReg_id = 1'b1; DataC_id = 1'b1; pc_id = 32'h80; RegDst_id = 2'b10;
        tick();
        tick();
        chk("pre_rst_res", alu_result_mem, 32'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_in();
        chk("mrst_res", alu_result_mem, 32'h0);
        chk("mrst_wdata", write_data_mem, 32'h0);
        chk("mrst_pc", pc_mem, 32'h0);
        chk("mrst_ctl", {27'b0, RegWrite_mem, MemtoReg_mem, DataC_mem, MemWrite_mem, MemRead_mem}, 32'h0);
        chk("mrst_regwr_exe", {31'b0, RegWrite_exe}, 32'd0);
        tick();
        chk("mrst_drain_res", alu_result_mem, 32'h0);
        chk("mrst_drain_wreg", {27'b0, write_reg_mem}, 32'h0);

        // rst and flush together behave as reset
        AluOp_id = 4'b0001; reg_data1_id = 32'h3; RegWrite_id = 1'b1; MemRead_id = 1'b1;
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0;
        clr_in();
        chk("rf_res", alu_result_mem, 32'h0);
        chk("rf_regwr_mem", {31'b0, RegWrite_mem}, 32'd0);
        chk("rf_memrd_exe", {31'b0, MemRead_exe}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/exe_pipe_slice.md
Name: exe_pipe_slice

Overview:
- Execute slice of the 5-stage MIPS pipeline: ID/EX pipeline register, execute-stage ALU with operand muxes and destination-register mux, and EX/MEM pipeline register.
- Takes decoded operands and controller signals from the ID stage and delivers the ALU result, store data, destination register and forwarded control to the MEM stage.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  load a bubble into the ID/EX register
- inst_extended_id  in  32  sign-extended immediate; bits [10:6] carry shamt
- reg_data1_id  in  32  rs read value
- reg_data2_id  in  32  rt read value
- rt_id  in  5  instruction[20:16]
- rd_id  in  5  instruction[15:11]
- pc_id  in  32  PC+4 of the instruction
- RegDst_id  in  2  00=rt, 01=rd, 10=r31, 11=rt
- AluOp_id  in  4  ALU operation code
- AluSrc_id  in  1  1: B = immediate; 0: B = reg_data2
- AluSrc1_id  in  1  1: A = shamt; 0: A = reg_data1
- MemRead_id, MemWrite_id, MemtoReg_id, DataC_id, RegWrite_id  in  1 each  downstream control
- write_reg_exe  out  5  EX-stage destination register (combinational, for hazard logic)
- RegWrite_exe, MemRead_exe  out  1 each  registered ID/EX copies (hazard logic)
- alu_result_mem  out  32  registered ALU result
- write_data_mem  out  32  registered reg_data2 (store data)
- write_reg_mem  out  5  registered destination register
- pc_mem  out  32  registered PC+4
- zero_mem  out  1  registered ALU zero flag
- MemRead_mem, MemWrite_mem, MemtoReg_mem, DataC_mem, RegWrite_mem  out  1 each  registered control

Behaviour:
- Both pipeline registers update on the rising clk edge. An input presented before edge N appears on the *_mem outputs after edge N+1 (2-cycle latency).
- rst=1 at an edge: every ID/EX and EX/MEM field is cleared to 0. All *_mem outputs read 0. This applies even when rst is asserted mid-stream.
- Priority is rst > flush.
- flush=1 (rst=0) at an edge: every ID/EX field loads 0, giving a NOP bubble with RegWrite, MemWrite and MemRead equal to 0. The EX/MEM register still captures the instruction currently in EX.
- The EX/MEM register has no flush.
- Operand selection:
  - shamt = {27'b0, inst_extended[10:6]}.
  - A = AluSrc1 ? shamt : reg_data1.
  - B = AluSrc ? inst_extended : reg_data2.
- ALU (combinational, 32-bit, wrap-around arithmetic, no overflow trap):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 0111 SLT: signed, result is 1 or 0.
  - 1001 SLTU: unsigned.
  - 1100 NOR.
  - 0100 SLL: B << A[4:0].
  - 0101 SRL: B >> A[4:0], logical.
  - 1000 SRA: B >>> A[4:0], arithmetic.
  - 1010 LUI: B << 16.
  - Any other code: result 0.
- zero = (result == 0).
- write_reg_exe is taken from the RegDst mux on the ID/EX rt/rd fields; 10 selects 31.
- write_data_mem is the ID/EX reg_data2, never the B operand.
- No internal forwarding; operands are used exactly as registered.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op constants (ALU_AND … ALU_LUI).
  - RegDst constants (DST_RT=2'b00, DST_RD=2'b01, DST_RA=2'b10).
  - Width constants.
- One natural sub-module: alu (A, B, op -> result, zero), combinational.
- Pipeline registers and muxes stay in the top module.

Test Plan:
- ADD, r-type: reg_data1=5, reg_data2=7, AluOp=0010, AluSrc=0, RegDst=01, rd=3, RegWrite=1 -> two edges later alu_result_mem=12, write_reg_mem=3, RegWrite_mem=1, zero_mem=0.
- SUB equal: operands both 0x1234, AluOp=0110 -> alu_result_mem=0, zero_mem=1. Then SLT with A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
- SLL via shamt: AluSrc1=1, inst_extended[10:6]=4, reg_data2=0x3 -> 0x30. SRA of 0x80000000 by 31 -> 0xFFFFFFFF.
- Store/immediate: AluSrc=1, inst_extended=0xFFFFFFFC, reg_data1=0x100, reg_data2=0xDEAD, MemWrite=1, RegWrite=0 -> alu_result_mem=0xFC, write_data_mem=0xDEAD, MemWrite_mem=1.
- JAL link: RegDst=10, pc_id=0x40 -> write_reg_exe=31 one edge after capture; write_reg_mem=31 and pc_mem=0x40 after the second edge.
- Flush/reset: flush=1 while a MemWrite=1 instruction enters -> next cycle RegWrite_exe=MemRead_exe=0 and, one edge later, MemWrite_mem=0. rst=1 with valid data in both registers -> all outputs 0 after one edge; rst and flush asserted together give the reset result.
